// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolve unit.
// Entry pc is sized for the widest supported XLEN; only the low XLEN bits are meaningful.
package branch_resolve_unit_pkg;

   localparam int unsigned XLEN_DEFAULT = 32;
   localparam int unsigned PC_MAX_W     = 64;
   localparam int unsigned PC_INC       = 4;
   localparam int unsigned CNT_W        = 32;

   typedef struct packed {
      logic                valid;
      logic                pred;
      logic [PC_MAX_W-1:0] pc;
   } bru_entry_t;

endpackage

// File: rtl/bru_perf_counter.sv
// Saturating branch / mispredict event counters for the branch resolve unit.
module bru_perf_counter
   import branch_resolve_unit_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             br_inc,
   input  logic             miss_inc,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   logic [CNT_W-1:0] br_cnt_q;
   logic [CNT_W-1:0] miss_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         br_cnt_q   <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (br_inc && (br_cnt_q != '1)) begin
            br_cnt_q <= br_cnt_q + CNT_W'(1);
         end
         if (miss_inc && (miss_cnt_q != '1)) begin
            miss_cnt_q <= miss_cnt_q + CNT_W'(1);
         end
      end
   end

   assign br_cnt   = br_cnt_q;
   assign miss_cnt = miss_cnt_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Tracks predicted branches from IF to EX and flags mispredictions with a same-cycle flush.
// Optional perf counters (br_cnt, miss_cnt) are enabled by defining BRU_PERF_CNT_EN.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int unsigned XLEN       = XLEN_DEFAULT,
   parameter int unsigned PIPE_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            B,
   input  logic            BrPre,
   input  logic [XLEN-1:0] if_pc,
   input  logic            ex_taken,
   input  logic [XLEN-1:0] ex_target,
   output logic            PreWrong,
   output logic            flush,
   output logic [XLEN-1:0] redirect_pc
`ifdef BRU_PERF_CNT_EN
   ,
   output logic [31:0]     br_cnt,
   output logic [31:0]     miss_cnt
`endif
);

   localparam int unsigned ExIdx = PIPE_DEPTH - 1;

   bru_entry_t      entry_q [PIPE_DEPTH];
   logic [XLEN-1:0] pc_ex;
   logic [XLEN-1:0] fall_through;
   logic            pre_wrong;

   always_comb begin
      pc_ex        = entry_q[ExIdx].pc[XLEN-1:0];
      fall_through = pc_ex + XLEN'(PC_INC);
      // A stalled EX stage must not resolve; it retries once the stall lifts.
      pre_wrong    = entry_q[ExIdx].valid & (entry_q[ExIdx].pred ^ ex_taken) & ~stall;
   end

   assign PreWrong    = pre_wrong;
   assign flush       = pre_wrong;
   assign redirect_pc = pre_wrong ? (ex_taken ? ex_target : fall_through) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            entry_q[i] <= '0;
         end
      end else if (pre_wrong) begin
         // Kill everything in flight; the IF instruction is dropped as well.
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            entry_q[i].valid <= 1'b0;
         end
      end else if (!stall) begin
         for (int i = PIPE_DEPTH - 1; i > 0; i--) begin
            entry_q[i] <= entry_q[i-1];
         end
         entry_q[0] <= '{valid: B, pred: BrPre, pc: PC_MAX_W'(if_pc)};
      end
   end

`ifdef BRU_PERF_CNT_EN
   bru_perf_counter u_perf (
      .clk      (clk),
      .rst      (rst),
      .br_inc   (entry_q[ExIdx].valid & ~stall),
      .miss_inc (pre_wrong),
      .br_cnt   (br_cnt),
      .miss_cnt (miss_cnt)
   );
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed vector table plus random run vs. a queue model.
module tb_branch_resolve_unit;

   localparam int unsigned XLEN = 32;
   localparam int unsigned PD   = 2;

   logic            clk = 1'b0;
   logic            rst, stall, B, BrPre, ex_taken;
   logic [XLEN-1:0] if_pc, ex_target, redirect_pc;
   logic            PreWrong, flush;
`ifdef BRU_PERF_CNT_EN
   logic [31:0]     br_cnt, miss_cnt;
`endif

   int total = 0;
   int bad   = 0;

   branch_resolve_unit #(.XLEN(XLEN), .PIPE_DEPTH(PD)) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .B           (B),
      .BrPre       (BrPre),
      .if_pc       (if_pc),
      .ex_taken    (ex_taken),
      .ex_target   (ex_target),
      .PreWrong    (PreWrong),
      .flush       (flush),
      .redirect_pc (redirect_pc)
`ifdef BRU_PERF_CNT_EN
      ,
      .br_cnt      (br_cnt),
      .miss_cnt    (miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, stall, b, bp;
      logic [31:0] pc;
      logic        tk;
      logic [31:0] tgt;
      logic        chk, pw;
      logic [31:0] rd;
   } vec_t;

   typedef struct {
      bit        v;
      bit        p;
      bit [31:0] pc;
   } ment_t;

   vec_t  vq[$];
   ment_t mq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic r, input logic s, input logic b, input logic bp,
                      input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                      input logic c, input logic pw, input logic [31:0] rd);
      vq.push_back('{rst: r, stall: s, b: b, bp: bp, pc: pc, tk: tk, tgt: tgt,
                     chk: c, pw: pw, rd: rd});
   endtask

   task automatic drive(input logic r, input logic s, input logic b, input logic bp,
                        input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      rst = r; stall = s; B = b; BrPre = bp; if_pc = pc; ex_taken = tk; ex_target = tgt;
   endtask

   initial begin
      ment_t       ex, ne;
      logic        exp_pw;
      logic [31:0] exp_rd;
      int unsigned br_m, miss_m;

      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);

      // Directed table, one row per cycle (PIPE_DEPTH = 2).
      //   rst stl b  bp pc            tk tgt           chk pw rd
      add(1, 0, 1, 1, 32'h10,       0, 32'h0,       0, 0, 32'h0);   // reset, entries unknown
      add(1, 0, 1, 1, 32'h10,       0, 32'h0,       1, 0, 32'h0);   // reset state
      add(0, 0, 0, 0, 32'h0,        1, 32'h0,       1, 0, 32'h0);
      add(0, 0, 0, 0, 32'h0,        1, 32'h0,       1, 0, 32'h0);
      add(0, 0, 1, 1, 32'h100,      0, 32'h0,       1, 0, 32'h0);   // pred T, actual NT
      add(0, 0, 0, 0, 32'h0,        0, 32'h0,       1, 0, 32'h0);
      add(0, 0, 0, 0, 32'h0,        0, 32'h0,       1, 1, 32'h104);
      add(0, 0, 0, 0, 32'h0,        0, 32'h0,       1, 0, 32'h0);   // single pulse
      add(0, 0, 1, 0, 32'h200,      0, 32'h0,       1, 0, 32'h0);   // pred NT, actual T
      add(0, 0, 1, 1, 32'h204,      1, 32'h0,       1, 0, 32'h0);
      add(0, 0, 1, 1, 32'h208,      1, 32'h80,      1, 1, 32'h80);
      add(0, 0, 0, 0, 32'h0,        0, 32'h0,       1, 0, 32'h0);   // younger entry killed
      add(0, 0, 0, 0, 32'h0,        0, 32'h0,       1, 0, 32'h0);   // IF instr killed
      add(0, 0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0,      1, 0, 32'h0);   // wrap
      add(0, 0, 0, 0, 32'h0,        0, 32'h0,       1, 0, 32'h0);
      add(0, 0, 0, 0, 32'h0,        0, 32'h0,       1, 1, 32'h0);
      add(0, 0, 1, 1, 32'h300,      0, 32'h0,       1, 0, 32'h0);   // correct prediction
      add(0, 0, 0, 0, 32'h0,        0, 32'h0,       1, 0, 32'h0);
      add(0, 0, 0, 0, 32'h0,        1, 32'h44,      1, 0, 32'h0);
      add(0, 0, 0, 0, 32'h0,        1, 32'h44,      1, 0, 32'h0);   // non-branch, taken
      add(0, 0, 1, 0, 32'h400,      0, 32'h0,       1, 0, 32'h0);   // stall case
      add(0, 0, 0, 0, 32'h0,        0, 32'h0,       1, 0, 32'h0);
      add(0, 1, 1, 1, 32'h999,      1, 32'h500,     1, 0, 32'h0);
      add(0, 1, 1, 1, 32'h999,      1, 32'h500,     1, 0, 32'h0);
      add(0, 1, 1, 1, 32'h999,      1, 32'h500,     1, 0, 32'h0);
      add(0, 0, 0, 0, 32'h0,        1, 32'h500,     1, 1, 32'h500);
      add(0, 0, 0, 0, 32'h0,        1, 32'h0,       1, 0, 32'h0);
      add(0, 0, 0, 0, 32'h0,        0, 32'h0,       1, 0, 32'h0);   // stalled IF never loaded
      add(0, 0, 1, 1, 32'h600,      0, 32'h0,       1, 0, 32'h0);   // reset mid-flight
      add(1, 0, 0, 0, 32'h0,        0, 32'h0,       1, 0, 32'h0);
      add(0, 0, 0, 0, 32'h0,        0, 32'h0,       1, 0, 32'h0);
      add(0, 0, 0, 0, 32'h0,        0, 32'h0,       1, 0, 32'h0);

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         drive(vq[i].rst, vq[i].stall, vq[i].b, vq[i].bp, vq[i].pc, vq[i].tk, vq[i].tgt);
         #1;
         if (vq[i].chk) begin
            chk($sformatf("vec%0d PreWrong", i), {31'b0, PreWrong}, {31'b0, vq[i].pw});
            chk($sformatf("vec%0d flush", i), {31'b0, flush}, {31'b0, vq[i].pw});
            chk($sformatf("vec%0d redirect_pc", i), redirect_pc, vq[i].rd);
         end
      end

`ifdef BRU_PERF_CNT_EN
      // Five branches, each resolving alone; the first two mispredict.
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h1000 + 32'(k * 4), 1'b0, '0);
         @(negedge clk);
         drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
         @(negedge clk);
         drive(1'b0, 1'b0, 1'b0, 1'b0, '0, (k < 2) ? 1'b0 : 1'b1, 32'h2000);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
      #1;
      chk("perf br_cnt", br_cnt, 32'd5);
      chk("perf miss_cnt", miss_cnt, 32'd2);
`endif

      // Randomised run against a queue model.
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
      @(posedge clk);
      mq.delete();
      for (int i = 0; i < PD; i++) mq.push_back('{v: 1'b0, p: 1'b0, pc: '0});
      br_m   = 0;
      miss_m = 0;

      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         rst       = ($urandom_range(0, 99) < 2);
         stall     = ($urandom_range(0, 3) == 0);
         B         = ($urandom_range(0, 2) != 0);
         BrPre     = $urandom_range(0, 1);
         if_pc     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
         ex_taken  = $urandom_range(0, 1);
         ex_target = $urandom;
         #1;
         ex     = mq[PD-1];
         exp_pw = ex.v && (ex.p != ex_taken) && !stall;
         exp_rd = exp_pw ? (ex_taken ? ex_target : ex.pc + 32'd4) : 32'd0;
         chk("rand PreWrong", {31'b0, PreWrong}, {31'b0, exp_pw});
         chk("rand flush", {31'b0, flush}, {31'b0, exp_pw});
         chk("rand redirect_pc", redirect_pc, exp_rd);
`ifdef BRU_PERF_CNT_EN
         chk("rand br_cnt", br_cnt, br_m);
         chk("rand miss_cnt", miss_cnt, miss_m);
`endif
         @(posedge clk);
         if (rst) begin
            foreach (mq[j]) mq[j] = '{v: 1'b0, p: 1'b0, pc: '0};
            br_m   = 0;
            miss_m = 0;
         end else begin
            if (ex.v && !stall && br_m != 32'hFFFF_FFFF) br_m++;
            if (exp_pw && miss_m != 32'hFFFF_FFFF) miss_m++;
            if (exp_pw) begin
               foreach (mq[j]) mq[j].v = 1'b0;
            end else if (!stall) begin
               ne = '{v: B, p: BrPre, pc: if_pc};
               void'(mq.pop_back());
               mq.push_front(ne);
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
